result_demux_1to2: RTL and testbench
====================================

Name: result_demux_1to2

Overview:
- Steers one 8-bit result stream into one of two destination channels, selected per beat. It is the inverse of the pipeline's 2:1 result select.
- Each destination channel has its own small FIFO, so a stalled channel does not block traffic already queued for the other.
- Output words are 9 bits wide, matching the 9-bit operand format consumed by the pipeline's select stage. Bit 8 is a tag bit; data sits in bits 7:0.
- Sits between the execute stage and the two writeback/forwarding consumers.

Parameters:
- DEPTH, 2, entries per output FIFO; must be a power of 2 and ≥2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  beat can be accepted this cycle.
- in_data  input  8  result byte.
- in_sel  input  1  destination: 0 = channel 0, 1 = channel 1.
- out0_valid  output  1  channel 0 head entry valid.
- out0_ready  input  1  channel 0 consumer takes the head entry.
- out0_data  output  9  channel 0 head entry; bit 8 = tag, bits 7:0 = data.
- out0_count  output  CNT_W  channel 0 occupancy.
- out1_valid, out1_ready, out1_data, out1_count: same as channel 0, for channel 1.

Behaviour:
- Reset: one clk, asynchronous, active-high. While rst is high:
  - all FIFO pointers and counts are 0;
  - out0_valid and out1_valid are 0;
  - out0_data and out1_data are 9'h000;
  - in_ready is 1 (both FIFOs are empty).
- Asserting rst mid-operation discards all queued entries immediately; there is no partial flush.
- in_ready = !full[in_sel]. It is combinational from in_sel and registered state only; it never depends on out*_ready.
- Accept condition: in_valid && in_ready. On accept:
  - the beat is written to FIFO[in_sel] at the write pointer;
  - the write pointer increments modulo DEPTH;
  - count increments.
- in_data/in_sel are don't-care while in_valid = 0. A non-accepted beat must be held stable by upstream.
- Pop condition per channel: outK_valid && outK_ready. On pop, the read pointer increments modulo DEPTH and count decrements.
- Ready asserted while a FIFO is empty is ignored; no underflow and no pointer movement.
- outK_valid = (countK != 0). outK_data shows the head entry, read from registered storage. outK_data is 9'h000 when the FIFO is empty.
- Latency: a beat accepted at edge N is visible on outK_valid/outK_data after edge N, i.e. one cycle later. There is no bypass path.
- Simultaneous push and pop on the same channel: both happen and count is unchanged.
  - Exception: a full FIFO does not accept a push even if it pops that cycle, because in_ready was low.
- Push to one channel and pop from the other in the same cycle: independent and both permitted.
- Ordering: FIFO order is preserved within each channel. There is no ordering guarantee across channels.
- Full: countK == DEPTH.
- Wrap-around: pointers are log2(DEPTH) bits wide and wrap naturally. Full/empty are derived from count, not from pointer comparison.
- Tag bit (bit 8): 0 unless the optional feature below is enabled.

Optional Feature:
- Macro: DEMUX_PARITY_EN.
- Defined: at write time, bit 8 of the stored word = ^in_data (XOR of the data bits). The stored word therefore has even parity over all 9 bits.
- Not defined: bit 8 is stored as 0, and no parity logic is present.
- Either way, bit 8 is carried through the FIFO unchanged.

Decomposition:
- Shared package (pipeline_pkg):
  - constants DATA_W = 8 and WORD_W = 9;
  - typedef word_t (9-bit);
  - localparams CH0 = 1'b0 and CH1 = 1'b1.
- Sub-module demux_chan_fifo:
  - parameterised by DEPTH;
  - ports: push, push_word, pop, head, valid, full, count;
  - instantiated twice.
- The top level holds only the steering and in_ready logic.

Test Plan:
- Reset check: assert rst, release → in_ready = 1, out*_valid = 0, out*_count = 0, out*_data = 9'h000.
- Basic steering: in_data = 8'hA5, in_sel = 0, out0_ready = 0 → next cycle out0_valid = 1, out0_data = 9'h0A5 (9'h0A5 with parity enabled: ^A5 = 0), out1_valid = 0. Then in_data = 8'h01, in_sel = 1 → out1_data = 9'h001, or 9'h101 with DEMUX_PARITY_EN.
- Full/backpressure on one channel only: push 3 beats to channel 1 with out1_ready = 0 → third beat sees in_ready = 0 and out1_count = 2. The same cycle with in_sel = 0 sees in_ready = 1 and is accepted.
- Push and pop on the same channel: out0_count = 1, push 8'h10 with out0_ready = 1 → count stays 1 and the head advances to 8'h10.
- Full FIFO with ready high: count = 2, out0_ready = 1, push attempted → push refused and count drops to 1.
- Wrap-around and reset: stream 8'h00..8'h0F to channel 0 with random out0_ready → output order exact, with no loss or duplication. Asserting rst with count = 2 → count = 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipeline_pkg : shared word format and channel ids for the pipeline |
// | Revision 1.0 : initial release                                     |
// +--------------------------------------------------------------------+
package pipeline_pkg;

  localparam int DATA_W = 8;
  localparam int WORD_W = 9;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/demux_chan_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_chan_fifo : per-channel FIFO, count-based full/empty         |
// | Revision 1.0    : initial release                                  |
// +--------------------------------------------------------------------+
module demux_chan_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_word,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic              valid,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("demux_chan_fifo: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  word_t             mem_q [DEPTH];
  word_t             mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              w_do_push;
  logic              w_do_pop;
  logic              w_full;
  logic              w_empty;

  assign w_full  = (count_q == CNT_W'(DEPTH));
  assign w_empty = (count_q == '0);

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    // Guards here keep the FIFO safe even if a caller ignores full/valid.
    w_do_push = push && !w_full;
    w_do_pop  = pop && !w_empty;

    if (w_do_push) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = w_empty ? '0 : mem_q[rd_ptr_q];
  assign valid = !w_empty;
  assign full  = w_full;
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/result_demux_1to2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | result_demux_1to2 : 1:2 result steering into per-channel FIFOs     |
// | Option macro      : DEMUX_PARITY_EN (bit 8 = even-parity tag)      |
// | Revision 1.0      : initial release                                |
// +--------------------------------------------------------------------+
module result_demux_1to2
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [WORD_W-1:0] out0_data,
  output logic [CNT_W-1:0]  out0_count,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [WORD_W-1:0] out1_data,
  output logic [CNT_W-1:0]  out1_count
);

  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_full;
  logic [1:0]       w_valid;
  word_t            w_head  [2];
  logic [CNT_W-1:0] w_count [2];
  word_t            w_in_word;
  logic             w_tag;
  logic             w_accept;

`ifdef DEMUX_PARITY_EN
  assign w_tag = ^in_data;
`else
  assign w_tag = 1'b0;
`endif

  always_comb begin
    w_in_word   = {w_tag, in_data};
    // in_ready looks only at the selected channel's registered fullness.
    in_ready    = (in_sel == CH1) ? !w_full[1] : !w_full[0];
    w_accept    = in_valid && in_ready;
    w_push      = '0;
    w_push[0]   = w_accept && (in_sel == CH0);
    w_push[1]   = w_accept && (in_sel == CH1);
    w_pop       = {out1_ready, out0_ready};
  end

  generate
    for (genvar k = 0; k < 2; k++) begin : g_chan
      demux_chan_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push[k]),
        .push_word (w_in_word),
        .pop       (w_pop[k]),
        .head      (w_head[k]),
        .valid     (w_valid[k]),
        .full      (w_full[k]),
        .count     (w_count[k])
      );
    end
  endgenerate

  assign out0_valid = w_valid[0];
  assign out0_data  = w_head[0];
  assign out0_count = w_count[0];
  assign out1_valid = w_valid[1];
  assign out1_data  = w_head[1];
  assign out1_count = w_count[1];

endmodule
`default_nettype wire

// File: tb/tb_result_demux_1to2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_result_demux_1to2 : randomized bench with queue reference model |
// | Revision 1.0         : initial release                             |
// +--------------------------------------------------------------------+
module tb_result_demux_1to2;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'h00;
  logic             in_sel = 1'b0;
  logic             out0_valid, out1_valid;
  logic             out0_ready = 1'b0, out1_ready = 1'b0;
  logic [8:0]       out0_data, out1_data;
  logic [CNT_W-1:0] out0_count, out1_count;

  int checks = 0;
  int failures = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         got0[$];

  always #5 clk = ~clk;

  result_demux_1to2 #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_count (out0_count),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_count (out1_count)
  );

  function automatic logic [8:0] exp_word(input logic [7:0] d);
`ifdef DEMUX_PARITY_EN
    return {^d, d};
`else
    return {1'b0, d};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready(input logic sel);
    return sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
  endfunction

  task automatic check_outputs();
    check("in_ready", {31'd0, in_ready}, {31'd0, model_ready(in_sel)});
    check("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
    check("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
    check("out0_count", 32'(out0_count), 32'(q0.size()));
    check("out1_count", 32'(out1_count), 32'(q1.size()));
    check("out0_data", 32'(out0_data), (q0.size() != 0) ? 32'(q0[0]) : 32'h0);
    check("out1_data", 32'(out1_data), (q1.size() != 0) ? 32'(q1[0]) : 32'h0);
  endtask

  // Drive one cycle, check pre-edge outputs, then advance the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic s,
                       input logic r0, input logic r1, output logic acc);
    logic rdy;
    in_valid = v; in_data = d; in_sel = s;
    out0_ready = r0; out1_ready = r1;
    #1;
    check_outputs();
    rdy = model_ready(s);
    acc = v && rdy;
    @(posedge clk);
    if (r0 && q0.size() != 0) got0.push_back(int'(q0.pop_front() & 9'h0FF));
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    if (acc) begin
      if (s) q1.push_back(exp_word(d));
      else   q0.push_back(exp_word(d));
    end
    #1;
  endtask

  initial begin
    logic acc;
    logic [7:0] nxt;
    logic       pend_v;
    logic [7:0] pend_d;
    logic       pend_s;

    // Reset held: outputs must already be in their reset state.
    #2;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs();

    // Basic steering.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, acc);
    #1;
    check("steer_ch0_data", 32'(out0_data), 32'h0A5);
    check("steer_ch1_idle", {31'd0, out1_valid}, 32'd0);
    cycle(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, acc);
`ifdef DEMUX_PARITY_EN
    check("steer_ch1_data", 32'(out1_data), 32'h101);
`else
    check("steer_ch1_data", 32'(out1_data), 32'h001);
`endif

    // Fill channel 1; third beat blocked, channel 0 still accepts.
    cycle(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, acc);
    check("ch1_full_refused", {31'd0, acc}, 32'd0);
    check("ch1_full_count", 32'(out1_count), 32'd2);
    cycle(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, acc);
    check("ch0_accept_while_ch1_full", {31'd0, acc}, 32'd1);

    // Drain channel 0 down to one entry, then push+pop same cycle.
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
    check("ch0_count_one", 32'(out0_count), 32'd1);
    cycle(1'b1, 8'h10, 1'b0, 1'b1, 1'b0, acc);
    check("pushpop_count", 32'(out0_count), 32'd1);
    check("pushpop_head", 32'(out0_data & 9'h0FF), 32'h10);

    // Full channel 0 with ready high: push refused, count drops.
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, acc);
    check("ch0_full", 32'(out0_count), 32'd2);
    cycle(1'b1, 8'h12, 1'b0, 1'b1, 1'b1, acc);
    check("full_pop_refused", {31'd0, acc}, 32'd0);
    check("full_pop_count", 32'(out0_count), 32'd1);

    // Drain both, with ready on an empty FIFO for a few cycles.
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);

    // Stream 0x00..0x0F to channel 0 with random consumer readiness.
    got0.delete();
    nxt = 8'h00;
    for (int i = 0; i < 400 && nxt < 8'h10; i++) begin
      cycle(1'b1, nxt, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom), acc);
      if (acc) nxt = nxt + 8'h01;
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
    check("stream_len", 32'(got0.size()), 32'd16);
    for (int i = 0; i < 16 && i < got0.size(); i++)
      check("stream_order", 32'(got0[i]), 32'(i));

    // Random traffic; a refused beat is held stable until accepted.
    pend_v = 1'b0; pend_d = 8'h00; pend_s = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!pend_v) begin
        pend_v = 1'($urandom_range(0, 3) != 0);
        pend_d = 8'($urandom);
        pend_s = 1'($urandom);
      end
      cycle(pend_v, pend_d, pend_s, 1'($urandom), 1'($urandom), acc);
      if (acc) pend_v = 1'b0;
    end

    // Asynchronous reset mid-cycle with channel 0 full.
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);
    cycle(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, acc);
    check("pre_reset_count", 32'(out0_count), 32'd2);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    check("async_rst_count0", 32'(out0_count), 32'd0);
    check("async_rst_valid0", {31'd0, out0_valid}, 32'd0);
    check("async_rst_data0", 32'(out0_data), 32'd0);
    check("async_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
